// File: rtl/key_pkg.sv
// Shared types and width helpers for the key conditioner slice.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Width of a counter that must be able to hold max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-FF synchroniser, debounce filter and auto-repeat FSM.
//
// state  | meaning
// IDLE   | no auto-repeat in progress
// DELAY  | key accepted as pressed, waiting for the first repeat
// REPEAT | issuing repeat pulses every REPEAT_PERIOD cycles
module key_channel
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int RP_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);
  localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

  logic            sync_1, sync_2, pressed_q;
  logic [DB_W-1:0] db_cnt;
  logic [RP_W-1:0] rp_cnt, rp_nxt;
  rep_state_t      state, state_nxt;
  logic            differ, accept, rise, fall, tick;

  assign differ = (pressed_q != level);
  assign accept = differ && (db_cnt == DB_LAST);
  assign rise   = accept && !level;
  assign fall   = accept && level;

  // Synchronisers reset to the released pin value so reset exit looks idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= RELEASED_RAW;
      sync_2    <= RELEASED_RAW;
      pressed_q <= 1'b0;
      db_cnt    <= '0;
      level     <= 1'b0;
    end else begin
      sync_1    <= key_raw;
      sync_2    <= sync_1;
      pressed_q <= sync_2 ^ RELEASED_RAW;
      level     <= level ^ accept;
      if (!differ || accept) db_cnt <= '0;
      else                   db_cnt <= db_cnt + 1'b1;
    end
  end

  // Release or disable overrides any pending repeat tick in the same cycle.
  always_comb begin
    state_nxt = state;
    rp_nxt    = rp_cnt;
    tick      = 1'b0;
    if (fall || !repeat_en) begin
      state_nxt = IDLE;
      rp_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = DELAY;
            rp_nxt    = '0;
          end
        end
        DELAY: begin
          if (rp_cnt == RD_LAST) begin
            tick      = 1'b1;
            rp_nxt    = '0;
            state_nxt = REPEAT;
          end else begin
            rp_nxt = rp_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rp_cnt == RP_LAST) begin
            tick   = 1'b1;
            rp_nxt = '0;
          end else begin
            rp_nxt = rp_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          rp_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rp_cnt        <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      rp_cnt        <= rp_nxt;
      press         <= rise | tick;
      release_pulse <= fall;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel push-button front end: per-channel conditioning plus a
// registered activity strobe for the entropy input.
module key_conditioner
  import key_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] keys_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                activity
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_raw       (keys_in[ch]),
      .repeat_en     (repeat_en[ch]),
      .level         (level[ch]),
      .press         (press[ch]),
      .release_pulse (release_pulse[ch])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) activity <= 1'b0;
    else        activity <= |press;
  end

endmodule
